// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] PC_INC = 32'd4;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return addr & ~(XLEN'(3));
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {instr, pc} entries; wrap-around pointers carry one
// extra bit so full and empty are distinguished without a separate flag.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic         clock,
   input  logic         resetN,
   input  logic         flush,
   input  logic         push,
   input  fetch_entry_t pushData,
   input  logic         pop,
   output fetch_entry_t head,
   output logic [AW:0]  count
);

   fetch_entry_t mem_q [DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic        do_push, do_pop;

   assign count   = wr_ptr_q - rd_ptr_q;
   assign do_push = push && !flush;
   assign do_pop  = pop && (count != '0);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         rd_ptr_d = wr_ptr_q;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (!resetN) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage is not reset; occupancy alone decides which entries are live.
   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= pushData;
   end

   assign head = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues credit-limited word requests and
// buffers in-order responses for the datapath; redirects drop stale returns.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter int DEPTH   = 4,
   parameter int MAX_OUT = 2,
   localparam int CW = $clog2(DEPTH)
) (
   input  logic        clock,
   input  logic        resetN,
   output logic        memReqValid,
   input  logic        memReqReady,
   output logic [31:0] memReqAddr,
   input  logic        memRespValid,
   input  logic [31:0] memRespData,
   output logic        instrValid,
   input  logic        instrReady,
   output logic [31:0] instr,
   output logic [31:0] instrPc,
   input  logic        redirectValid,
   input  logic [31:0] redirectTarget,
   output logic [CW:0] fifoCount,
   output logic        errStray
);

   localparam int OW = $clog2(MAX_OUT + 1);
   localparam int SW = CW + OW + 2;

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] resp_pc_q, resp_pc_d;
   logic [OW-1:0]   out_q, out_d;
   logic [OW-1:0]   drop_q, drop_d;
   logic            err_q, err_d;

   logic [CW:0]     fifo_count;
   fetch_entry_t    fifo_head;
   fetch_entry_t    push_entry;
   logic [SW-1:0]   inflight;
   logic            credit_ok, fire, pop, push, resp_tracked;
   logic [XLEN-1:0] target;

   // Entries already buffered plus live (non-stale) requests must fit the FIFO.
   assign inflight  = SW'(fifo_count) + SW'(out_q) - SW'(drop_q);
   assign credit_ok = inflight < SW'(DEPTH);

   assign memReqValid  = resetN && !redirectValid && (out_q < OW'(MAX_OUT)) && credit_ok;
   assign memReqAddr   = resetN ? fetch_pc_q : '0;
   assign fire         = memReqValid && memReqReady;
   assign resp_tracked = memRespValid && (out_q != '0);
   assign push         = resp_tracked && (drop_q == '0) && !redirectValid;
   assign pop          = instrValid && instrReady;
   assign target       = word_align(redirectTarget);
   assign push_entry   = '{instr: memRespData, pc: resp_pc_q};

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      out_d      = out_q;
      drop_d     = drop_q;
      err_d      = err_q | (memRespValid && (out_q == '0));

      case ({fire, resp_tracked})
         2'b10:   out_d = out_q + OW'(1);
         2'b01:   out_d = out_q - OW'(1);
         default: out_d = out_q;
      endcase

      if (redirectValid) begin
         fetch_pc_d = target;
         resp_pc_d  = target;
         drop_d     = out_q - OW'(resp_tracked);
      end else begin
         if (fire) fetch_pc_d = fetch_pc_q + PC_INC;
         if (push) resp_pc_d  = resp_pc_q + PC_INC;
         if (resp_tracked && (drop_q != '0)) drop_d = drop_q - OW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (!resetN) begin
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         out_q      <= '0;
         drop_q     <= '0;
         err_q      <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         out_q      <= out_d;
         drop_q     <= drop_d;
         err_q      <= err_d;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock    (clock),
      .resetN   (resetN),
      .flush    (redirectValid),
      .push     (push),
      .pushData (push_entry),
      .pop      (pop),
      .head     (fifo_head),
      .count    (fifo_count)
   );

   assign fifoCount  = fifo_count;
   assign instrValid = fifo_count != '0;
   assign instr      = instrValid ? fifo_head.instr : '0;
   assign instrPc    = instrValid ? fifo_head.pc : '0;
   assign errStray   = err_q;

endmodule
